// File: rtl/uart_spi_bridge_pkg.sv
// +----------------------------------------------------------------------------+
// | uart_spi_bridge_pkg                                                        |
// | Command codes, state encoding and dummy byte for the UART-to-SPI bridge.   |
// | Optional build macro: BRIDGE_CHECKSUM_EN (adds the ST_CSUM state).         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_spi_bridge_pkg;

    localparam logic [7:0] CMD_BOOT   = 8'h00;
    localparam logic [7:0] CMD_XFER   = 8'h01;
    localparam logic [7:0] CMD_ID     = 8'h02;
    localparam logic [7:0] DUMMY_BYTE = 8'hFF;

    typedef enum logic [3:0] {
        ST_CMD      = 4'd0,
        ST_BOOT_IDX = 4'd1,
        ST_BOOT     = 4'd2,
        ST_CS_IDX   = 4'd3,
        ST_TXLEN    = 4'd4,
        ST_RXLEN    = 4'd5,
        ST_TX       = 4'd6,
        ST_RX       = 4'd7,
        ST_ID       = 4'd8
`ifdef BRIDGE_CHECKSUM_EN
        ,
        ST_CSUM     = 4'd9
`endif
    } state_e;

endpackage

`default_nettype wire

// File: rtl/uart_bridge_timeout.sv
// +----------------------------------------------------------------------------+
// | uart_bridge_timeout                                                        |
// | Counts consecutive enabled cycles without a restart; pulses expired on the |
// | TIMEOUT_CYCLES-th such cycle.                                              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_bridge_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expired = enable && !restart && (count_q == LAST);

    always_comb begin
        count_d = count_q + 1'b1;
        if (!enable || restart || expired) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_spi_bridge.sv
// +----------------------------------------------------------------------------+
// | uart_spi_bridge                                                            |
// | Host byte-stream protocol front end driving an SPI byte engine, boot       |
// | request and slave selects. Optional build macro: BRIDGE_CHECKSUM_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_spi_bridge
    import uart_spi_bridge_pkg::*;
#(
    parameter int unsigned NUM_CS         = 2,
    parameter int unsigned LEN_BYTES      = 2,
    parameter int unsigned IMG_W          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1200000,
    parameter logic [7:0]  VERSION        = 8'h02
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx_valid,
    output logic              uart_rx_ready,
    input  logic [7:0]        uart_rx_data,
    input  logic              uart_rx_break,
    output logic              uart_tx_valid,
    input  logic              uart_tx_ready,
    output logic [7:0]        uart_tx_data,
    output logic              spi_tx_valid,
    input  logic              spi_tx_ready,
    output logic [7:0]        spi_tx_data,
    input  logic              spi_rx_valid,
    output logic              spi_rx_ready,
    input  logic [7:0]        spi_rx_data,
    output logic [NUM_CS-1:0] spi_ss,
    output logic              led,
    output logic              boot,
    output logic [IMG_W-1:0]  boot_image
);

    localparam int unsigned       LEN_W    = 8 * LEN_BYTES;
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [1:0]        LAST_IDX = 2'(LEN_BYTES - 1);
    localparam logic [7:0]        NUM_CS_B = 8'(NUM_CS);
    localparam logic [NUM_CS-1:0] SS_ONE   = NUM_CS'(1);

    state_e              state_q, state_d;
    logic [7:0]          cs_q, cs_d;
    logic [LEN_W-1:0]    tx_len_q, tx_len_d;
    logic [LEN_W-1:0]    rx_len_q, rx_len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          idx_q, idx_d;
    logic [NUM_CS-1:0]   ss_q, ss_d;
    logic                boot_q, boot_d;
    logic [IMG_W-1:0]    img_q, img_d;

    logic tmo_enable;
    logic tmo_expired;

    // Header states always accept, so a valid byte is itself the handshake.
    assign tmo_enable = (state_q == ST_BOOT_IDX) || (state_q == ST_CS_IDX) ||
                        (state_q == ST_TXLEN)    || (state_q == ST_RXLEN);

    uart_bridge_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .restart (uart_rx_valid),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

`ifdef BRIDGE_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (state_q != ST_RX && state_d == ST_RX) begin
            csum_d = '0;
        end else if (state_q == ST_RX && spi_rx_valid && uart_tx_ready) begin
            csum_d = csum_q ^ spi_rx_data;
        end
        if (uart_rx_break) begin
            csum_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    always_comb begin
        state_d       = state_q;
        cs_d          = cs_q;
        tx_len_d      = tx_len_q;
        rx_len_d      = rx_len_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        img_d         = img_q;
        uart_rx_ready = 1'b0;
        uart_tx_valid = 1'b0;
        uart_tx_data  = 8'h00;
        spi_tx_valid  = 1'b0;
        spi_tx_data   = 8'h00;
        spi_rx_ready  = 1'b0;

        case (state_q)
            ST_CMD: begin
                uart_rx_ready = 1'b1;
                if (uart_rx_valid) begin
                    case (uart_rx_data)
                        CMD_BOOT: state_d = ST_BOOT_IDX;
                        CMD_XFER: state_d = ST_CS_IDX;
                        CMD_ID:   state_d = ST_ID;
                        default:  state_d = ST_CMD;
                    endcase
                end
            end
            ST_BOOT_IDX: begin
                uart_rx_ready = 1'b1;
                if (uart_rx_valid) begin
                    img_d   = uart_rx_data[IMG_W-1:0];
                    state_d = ST_BOOT;
                end
            end
            ST_BOOT: begin
                uart_rx_ready = 1'b1;
            end
            ST_CS_IDX: begin
                uart_rx_ready = 1'b1;
                if (uart_rx_valid) begin
                    cs_d    = uart_rx_data;
                    idx_d   = '0;
                    state_d = ST_TXLEN;
                end
            end
            ST_TXLEN: begin
                uart_rx_ready = 1'b1;
                if (uart_rx_valid) begin
                    tx_len_d[{idx_q, 3'b000} +: 8] = uart_rx_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_RXLEN;
                    end
                end
            end
            ST_RXLEN: begin
                uart_rx_ready = 1'b1;
                if (uart_rx_valid) begin
                    rx_len_d[{idx_q, 3'b000} +: 8] = uart_rx_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (tx_len_q != '0) begin
                            state_d = ST_TX;
                            cnt_d   = tx_len_q;
                        end else if (rx_len_d != '0) begin
                            state_d = ST_RX;
                            cnt_d   = rx_len_d;
                        end else begin
                            state_d = ST_CMD;
                        end
                    end
                end
            end
            ST_TX: begin
                spi_tx_valid  = uart_rx_valid;
                uart_rx_ready = spi_tx_ready;
                spi_tx_data   = uart_rx_data;
                spi_rx_ready  = 1'b1;
                if (spi_rx_valid) begin
                    cnt_d = cnt_q - LEN_ONE;
                    if (cnt_q == LEN_ONE) begin
                        if (rx_len_q != '0) begin
                            state_d = ST_RX;
                            cnt_d   = rx_len_q;
                        end else begin
                            state_d = ST_CMD;
                        end
                    end
                end
            end
            ST_RX: begin
                spi_tx_valid  = 1'b1;
                spi_tx_data   = DUMMY_BYTE;
                uart_tx_valid = spi_rx_valid;
                spi_rx_ready  = uart_tx_ready;
                uart_tx_data  = spi_rx_data;
                if (spi_rx_valid && uart_tx_ready) begin
                    cnt_d = cnt_q - LEN_ONE;
                    if (cnt_q == LEN_ONE) begin
`ifdef BRIDGE_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_CMD;
`endif
                    end
                end
            end
            ST_ID: begin
                uart_tx_valid = 1'b1;
                uart_tx_data  = VERSION;
                if (uart_tx_ready) begin
                    state_d = ST_CMD;
                end
            end
`ifdef BRIDGE_CHECKSUM_EN
            ST_CSUM: begin
                uart_tx_valid = 1'b1;
                uart_tx_data  = csum_q;
                if (uart_tx_ready) begin
                    state_d = ST_CMD;
                end
            end
`endif
            default: state_d = ST_CMD;
        endcase

        if (tmo_expired) begin
            state_d = ST_CMD;
            idx_d   = '0;
        end

        // Break wins over everything: swallow the byte and squash all traffic.
        if (uart_rx_break) begin
            state_d       = ST_CMD;
            cs_d          = '0;
            tx_len_d      = '0;
            rx_len_d      = '0;
            cnt_d         = '0;
            idx_d         = '0;
            uart_rx_ready = 1'b1;
            uart_tx_valid = 1'b0;
            spi_tx_valid  = 1'b0;
            spi_rx_ready  = 1'b0;
        end
    end

    always_comb begin
        ss_d = '1;
        if ((state_d == ST_TX || state_d == ST_RX) && (cs_q < NUM_CS_B)) begin
            ss_d = ~(SS_ONE << cs_q);
        end
        boot_d = (state_d == ST_BOOT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_CMD;
            cs_q     <= '0;
            tx_len_q <= '0;
            rx_len_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            ss_q     <= '1;
            boot_q   <= 1'b0;
            img_q    <= '0;
        end else begin
            state_q  <= state_d;
            cs_q     <= cs_d;
            tx_len_q <= tx_len_d;
            rx_len_q <= rx_len_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            ss_q     <= ss_d;
            boot_q   <= boot_d;
            img_q    <= img_d;
        end
    end

    assign spi_ss     = ss_q;
    assign boot       = boot_q;
    assign boot_image = img_q;
    assign led        = (state_q != ST_CMD);

endmodule

`default_nettype wire

// File: tb/tb_uart_spi_bridge.sv
// +----------------------------------------------------------------------------+
// | tb_uart_spi_bridge                                                         |
// | Self-checking bench: host driver, one-outstanding SPI engine model,        |
// | transfer vector table and hand sequences. Honours BRIDGE_CHECKSUM_EN.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_spi_bridge;

    localparam int         NUM_CS = 2;
    localparam int         LEN_B  = 2;
    localparam int         IMG_W  = 2;
    localparam int         TMO    = 40;
    localparam logic [7:0] VER    = 8'h02;
    localparam logic [NUM_CS-1:0] SS_IDLE = '1;

    typedef logic [NUM_CS+7:0] spi_rec_t;

    typedef struct {
        logic [7:0]        cs;
        int                txlen;
        int                rxlen;
        logic [7:0]        txbase;
        logic [7:0]        seed;
        logic [NUM_CS-1:0] exp_ss;
    } xfer_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              uart_rx_valid = 1'b0;
    logic              uart_rx_ready;
    logic [7:0]        uart_rx_data = 8'h00;
    logic              uart_rx_break = 1'b0;
    logic              uart_tx_valid;
    logic              uart_tx_ready = 1'b1;
    logic [7:0]        uart_tx_data;
    logic              spi_tx_valid;
    logic              spi_tx_ready;
    logic [7:0]        spi_tx_data;
    logic              spi_rx_valid;
    logic              spi_rx_ready;
    logic [7:0]        spi_rx_data;
    logic [NUM_CS-1:0] spi_ss;
    logic              led;
    logic              boot;
    logic [IMG_W-1:0]  boot_image;

    int total = 0;
    int bad   = 0;

    logic [7:0] resp_q[$];
    spi_rec_t   spi_got[$];
    spi_rec_t   exp_spi[$];
    logic [7:0] host_got[$];
    logic [7:0] exp_host[$];

    always #5 clk = ~clk;

    uart_spi_bridge #(
        .NUM_CS         (NUM_CS),
        .LEN_BYTES      (LEN_B),
        .IMG_W          (IMG_W),
        .TIMEOUT_CYCLES (TMO),
        .VERSION        (VER)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_break (uart_rx_break),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_tx_data  (uart_tx_data),
        .spi_tx_valid  (spi_tx_valid),
        .spi_tx_ready  (spi_tx_ready),
        .spi_tx_data   (spi_tx_data),
        .spi_rx_valid  (spi_rx_valid),
        .spi_rx_ready  (spi_rx_ready),
        .spi_rx_data   (spi_rx_data),
        .spi_ss        (spi_ss),
        .led           (led),
        .boot          (boot),
        .boot_image    (boot_image)
    );

    // SPI engine: one byte in flight, answer after a short delay.
    logic       pend_q = 1'b0;
    logic       rvalid_q = 1'b0;
    logic [7:0] rdata_q = 8'h00;
    logic [1:0] dly_q = 2'd0;

    assign spi_tx_ready = !pend_q;
    assign spi_rx_valid = rvalid_q;
    assign spi_rx_data  = rdata_q;

    always @(posedge clk) begin
        if (rst) begin
            pend_q   <= 1'b0;
            rvalid_q <= 1'b0;
            dly_q    <= 2'd0;
        end else if (spi_tx_valid && spi_tx_ready) begin
            spi_got.push_back({spi_ss, spi_tx_data});
            pend_q <= 1'b1;
            dly_q  <= 2'd2;
            if (resp_q.size() > 0) rdata_q <= resp_q.pop_front();
            else                   rdata_q <= 8'h00;
        end else if (pend_q && !rvalid_q) begin
            if (dly_q == 2'd0) rvalid_q <= 1'b1;
            else               dly_q <= dly_q - 2'd1;
        end else if (rvalid_q && spi_rx_ready) begin
            rvalid_q <= 1'b0;
            pend_q   <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (!rst && uart_tx_valid && uart_tx_ready) host_got.push_back(uart_tx_data);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        uart_rx_valid = 1'b1;
        uart_rx_data  = b;
        #1;
        while (!uart_rx_ready && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rx_accept", {31'b0, uart_rx_ready}, 32'd1);
        @(posedge clk);
        #1;
        uart_rx_valid = 1'b0;
    endtask

    task automatic do_break();
        @(negedge clk);
        uart_rx_break = 1'b1;
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h01;
        #1;
        chk("break_rx_ready", {31'b0, uart_rx_ready}, 32'd1);
        @(posedge clk);
        #1;
        uart_rx_break = 1'b0;
        uart_rx_valid = 1'b0;
        chk("break_led", {31'b0, led}, 32'd0);
        chk("break_boot", {31'b0, boot}, 32'd0);
        chk("break_ss", {30'b0, spi_ss}, {30'b0, SS_IDLE});
    endtask

    task automatic clear_queues();
        resp_q.delete();
        spi_got.delete();
        exp_spi.delete();
        host_got.delete();
        exp_host.delete();
    endtask

    task automatic drain_check();
        int n = 0;
        while ((led || spi_got.size() < exp_spi.size() || host_got.size() < exp_host.size())
               && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("xfer_led_idle", {31'b0, led}, 32'd0);
        cycles(3);
        chk("ss_after", {30'b0, spi_ss}, {30'b0, SS_IDLE});
        chk("spi_count", spi_got.size(), exp_spi.size());
        chk("host_count", host_got.size(), exp_host.size());
        while (exp_spi.size() > 0 && spi_got.size() > 0) begin
            spi_rec_t e, a;
            e = exp_spi.pop_front();
            a = spi_got.pop_front();
            chk("spi_byte", {22'b0, a}, {22'b0, e});
        end
        while (exp_host.size() > 0 && host_got.size() > 0) begin
            logic [7:0] e, a;
            e = exp_host.pop_front();
            a = host_got.pop_front();
            chk("host_byte", {24'b0, a}, {24'b0, e});
        end
        clear_queues();
    endtask

    task automatic run_xfer(input xfer_t v);
        logic [7:0] r;
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < v.txlen + v.rxlen; k++) begin
            r = 8'(v.seed * (k + 1));
            resp_q.push_back(r);
            if (k < v.txlen) begin
                exp_spi.push_back({v.exp_ss, 8'(v.txbase + 8'h11 * k)});
            end else begin
                exp_spi.push_back({v.exp_ss, 8'hFF});
                exp_host.push_back(r);
                x = x ^ r;
            end
        end
`ifdef BRIDGE_CHECKSUM_EN
        if (v.rxlen > 0) exp_host.push_back(x);
`endif
        send_byte(8'h01);
        send_byte(v.cs);
        send_byte(8'(v.txlen));
        send_byte(8'(v.txlen >> 8));
        send_byte(8'(v.rxlen));
        send_byte(8'(v.rxlen >> 8));
        for (int k = 0; k < v.txlen; k++) begin
            send_byte(8'(v.txbase + 8'h11 * k));
        end
        drain_check();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        xfer_t vec[6];
        vec[0] = '{8'd1, 2,   1, 8'hAA, 8'h37, 2'b01};
        vec[1] = '{8'd0, 1,   0, 8'h5C, 8'h13, 2'b10};
        vec[2] = '{8'd0, 0,   3, 8'h00, 8'h11, 2'b10};
        vec[3] = '{8'd5, 2,   2, 8'h10, 8'h29, 2'b11};
        vec[4] = '{8'd1, 0,   0, 8'h00, 8'h00, 2'b11};
        vec[5] = '{8'd1, 256, 2, 8'h01, 8'h07, 2'b01};

        cycles(3);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ss", {30'b0, spi_ss}, {30'b0, SS_IDLE});
        chk("rst_boot", {31'b0, boot}, 32'd0);
        chk("rst_image", {30'b0, boot_image}, 32'd0);
        chk("rst_led", {31'b0, led}, 32'd0);
        chk("rst_uart_tx_valid", {31'b0, uart_tx_valid}, 32'd0);
        chk("rst_spi_tx_valid", {31'b0, spi_tx_valid}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_xfer(vec[i]);
        end

        // Boot request, extra bytes swallowed, then break.
        send_byte(8'h00);
        send_byte(8'h03);
        chk("boot_set", {31'b0, boot}, 32'd1);
        chk("boot_image", {30'b0, boot_image}, 32'd3);
        chk("boot_led", {31'b0, led}, 32'd1);
        send_byte(8'h02);
        chk("boot_hold", {31'b0, boot}, 32'd1);
        chk("boot_no_id", {31'b0, uart_tx_valid}, 32'd0);
        do_break();

        // ID reply held while the host stalls.
        @(negedge clk);
        uart_tx_ready = 1'b0;
        send_byte(8'h02);
        for (int i = 0; i < 5; i++) begin
            chk("id_valid_hold", {31'b0, uart_tx_valid}, 32'd1);
            chk("id_data_hold", {24'b0, uart_tx_data}, {24'b0, VER});
            cycles(1);
        end
        exp_host.push_back(VER);
        @(negedge clk);
        uart_tx_ready = 1'b1;
        drain_check();

        // Abandoned header times out after exactly TMO idle cycles.
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h00);
        cycles(TMO - 1);
        chk("tmo_not_yet", {31'b0, led}, 32'd1);
        cycles(1);
        chk("tmo_expired", {31'b0, led}, 32'd0);
        send_byte(8'h02);
        exp_host.push_back(VER);
        drain_check();

        // Reset in the middle of a 4-byte write.
        resp_q.push_back(8'h77);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h04);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'hAA);
        cycles(5);
        chk("midtx_ss_low", {30'b0, spi_ss}, 32'h2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midtx_rst_ss", {30'b0, spi_ss}, {30'b0, SS_IDLE});
        chk("midtx_rst_led", {31'b0, led}, 32'd0);
        chk("midtx_rst_spi_valid", {31'b0, spi_tx_valid}, 32'd0);
        clear_queues();
        send_byte(8'h00);
        send_byte(8'h01);
        chk("post_rst_boot", {31'b0, boot}, 32'd1);
        chk("post_rst_image", {30'b0, boot_image}, 32'd1);
        do_break();

        cycles(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
